// File: rtl/fft_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fft_pkg : shared Q7.8 FFT types, rescale and saturation helpers      |
// | Revision: 1.0                                                        |
// +--------------------------------------------------------------------+
package fft_pkg;

   localparam int DATA_W = 16;
   localparam int FRAC_W = 8;
   localparam int PROD_W = 2 * DATA_W;
   localparam logic signed [PROD_W-1:0] ROUND_BIAS = PROD_W'(2 ** (FRAC_W - 1));

   typedef struct packed {
      logic signed [DATA_W-1:0] re;
      logic signed [DATA_W-1:0] im;
   } cplx_t;

   // Round-half-up back to Q7.8; the result wraps to DATA_W bits.
   function automatic logic signed [DATA_W-1:0] rescale(input logic signed [PROD_W-1:0] p);
      return DATA_W'((p + ROUND_BIAS) >>> FRAC_W);
   endfunction

   function automatic logic sat_hit(input logic signed [DATA_W:0] s);
      return s[DATA_W] != s[DATA_W-1];
   endfunction

   function automatic logic signed [DATA_W-1:0] saturate(input logic signed [DATA_W:0] s);
      if (s[DATA_W] != s[DATA_W-1])
         return s[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
      return s[DATA_W-1:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/bf_radix2_dit_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bf_radix2_dit_if : valid/ready sample bus of the DIT butterfly       |
// | Revision: 1.0                                                        |
// +--------------------------------------------------------------------+
interface bf_radix2_dit_if;
   import fft_pkg::*;

   logic                     in_valid;
   logic                     in_ready;
   logic                     inverse;
   logic signed [DATA_W-1:0] A_re;
   logic signed [DATA_W-1:0] A_im;
   logic signed [DATA_W-1:0] B_re;
   logic signed [DATA_W-1:0] B_im;
   logic signed [DATA_W-1:0] W_re;
   logic signed [DATA_W-1:0] W_im;
   logic                     out_valid;
   logic                     out_ready;
   logic signed [DATA_W-1:0] Y0_re;
   logic signed [DATA_W-1:0] Y0_im;
   logic signed [DATA_W-1:0] Y1_re;
   logic signed [DATA_W-1:0] Y1_im;
   logic                     ovf;

   modport master (
      output in_valid, inverse, A_re, A_im, B_re, B_im, W_re, W_im, out_ready,
      input  in_ready, out_valid, Y0_re, Y0_im, Y1_re, Y1_im, ovf
   );

   modport slave (
      input  in_valid, inverse, A_re, A_im, B_re, B_im, W_re, W_im, out_ready,
      output in_ready, out_valid, Y0_re, Y0_im, Y1_re, Y1_im, ovf
   );

endinterface
`default_nettype wire

// File: rtl/cmul_q78.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cmul_q78 : two-stage Q7.8 complex multiply B*W (or B*conj(W))        |
// | Revision: 1.0                                                        |
// +--------------------------------------------------------------------+
module cmul_q78
   import fft_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  en,
   input  logic  in_valid,
   input  logic  inverse,
   input  cplx_t a,
   input  cplx_t b,
   input  cplx_t w,
   output logic  out_valid,
   output cplx_t a_out,
   output cplx_t z
);

   logic                     s1_valid;
   cplx_t                    s1_a;
   cplx_t                    s1_b;
   cplx_t                    s1_w;
   logic                     s2_valid;
   cplx_t                    s2_a;
   logic signed [PROD_W-1:0] p_rr;
   logic signed [PROD_W-1:0] p_ii;
   logic signed [PROD_W-1:0] p_ri;
   logic signed [PROD_W-1:0] p_ir;
   logic signed [DATA_W-1:0] w_im_sel;
   logic signed [DATA_W-1:0] z_re;
   logic signed [DATA_W-1:0] z_im;

   // Conjugation is folded into capture; -(-32768) wraps back to -32768.
   assign w_im_sel = inverse ? -w.im : w.im;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
      end else if (en) begin
         s1_valid <= in_valid;
         s2_valid <= s1_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (en) begin
         s1_a    <= a;
         s1_b    <= b;
         s1_w    <= '{re: w.re, im: w_im_sel};
         s2_a    <= s1_a;
         p_rr    <= $signed(s1_b.re) * $signed(s1_w.re);
         p_ii    <= $signed(s1_b.im) * $signed(s1_w.im);
         p_ri    <= $signed(s1_b.re) * $signed(s1_w.im);
         p_ir    <= $signed(s1_b.im) * $signed(s1_w.re);
      end
   end

   assign z_re      = rescale(p_rr) - rescale(p_ii);
   assign z_im      = rescale(p_ri) + rescale(p_ir);
   assign z         = '{re: z_re, im: z_im};
   assign a_out     = s2_a;
   assign out_valid = s2_valid;

endmodule
`default_nettype wire

// File: rtl/bf_radix2_dit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bf_radix2_dit : pipelined radix-2 DIT butterfly Y0=A+BW, Y1=A-BW     |
// | Build option: BF_RADIX2_SAT_EN saturates the outputs and drives ovf. |
// | Revision: 1.0                                                        |
// +--------------------------------------------------------------------+
module bf_radix2_dit
   import fft_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   bf_radix2_dit_if.slave  bus
);

   logic                     en;
   logic                     mul_valid;
   cplx_t                    a_in;
   cplx_t                    b_in;
   cplx_t                    w_in;
   cplx_t                    mul_a;
   cplx_t                    z;
   logic                     out_valid;
   logic signed [DATA_W-1:0] y0_re;
   logic signed [DATA_W-1:0] y0_im;
   logic signed [DATA_W-1:0] y1_re;
   logic signed [DATA_W-1:0] y1_im;

   // One stall signal freezes every stage whenever the output is held.
   assign en           = !out_valid || bus.out_ready;
   assign bus.in_ready = en || rst;

   assign a_in = '{re: bus.A_re, im: bus.A_im};
   assign b_in = '{re: bus.B_re, im: bus.B_im};
   assign w_in = '{re: bus.W_re, im: bus.W_im};

   cmul_q78 u_cmul (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .in_valid  (bus.in_valid),
      .inverse   (bus.inverse),
      .a         (a_in),
      .b         (b_in),
      .w         (w_in),
      .out_valid (mul_valid),
      .a_out     (mul_a),
      .z         (z)
   );

`ifdef BF_RADIX2_SAT_EN
   logic signed [DATA_W:0] s0_re;
   logic signed [DATA_W:0] s0_im;
   logic signed [DATA_W:0] s1_re;
   logic signed [DATA_W:0] s1_im;
   logic                   ovf;

   assign s0_re = {mul_a.re[DATA_W-1], mul_a.re} + {z.re[DATA_W-1], z.re};
   assign s0_im = {mul_a.im[DATA_W-1], mul_a.im} + {z.im[DATA_W-1], z.im};
   assign s1_re = {mul_a.re[DATA_W-1], mul_a.re} - {z.re[DATA_W-1], z.re};
   assign s1_im = {mul_a.im[DATA_W-1], mul_a.im} - {z.im[DATA_W-1], z.im};

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         ovf       <= 1'b0;
      end else if (en) begin
         out_valid <= mul_valid;
         ovf       <= mul_valid & (sat_hit(s0_re) | sat_hit(s0_im) |
                                   sat_hit(s1_re) | sat_hit(s1_im));
      end
   end

   always_ff @(posedge clk) begin
      if (en) begin
         y0_re <= saturate(s0_re);
         y0_im <= saturate(s0_im);
         y1_re <= saturate(s1_re);
         y1_im <= saturate(s1_im);
      end
   end

   assign bus.ovf = ovf;
`else
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
      end else if (en) begin
         out_valid <= mul_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (en) begin
         y0_re <= mul_a.re + z.re;
         y0_im <= mul_a.im + z.im;
         y1_re <= mul_a.re - z.re;
         y1_im <= mul_a.im - z.im;
      end
   end

   assign bus.ovf = 1'b0;
`endif

   assign bus.out_valid = out_valid;
   assign bus.Y0_re     = y0_re;
   assign bus.Y0_im     = y0_im;
   assign bus.Y1_re     = y1_re;
   assign bus.Y1_im     = y1_im;

endmodule
`default_nettype wire

// File: tb/tb_bf_radix2_dit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_bf_radix2_dit : directed self-checking bench for bf_radix2_dit    |
// | Revision: 1.0                                                        |
// +--------------------------------------------------------------------+
module tb_bf_radix2_dit;

   logic clk = 1'b0;
   logic rst;
   int   applied     = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   bf_radix2_dit_if bus ();

   bf_radix2_dit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Independent integer reference; returns {ovf, Y0_re, Y0_im, Y1_re, Y1_im}.
   function automatic logic [64:0] golden(input logic [15:0] ar, ai, br, bi, wr, wi,
                                          input logic inv);
      logic signed [15:0] wis;
      logic signed [15:0] zr;
      logic signed [15:0] zi;
      int                 rr, ii, ri, ir;
      int                 s [4];
      logic [15:0]        y [4];
      logic               ov;
      wis = inv ? 16'(-int'($signed(wi))) : wi;
      rr  = (int'($signed(br)) * int'($signed(wr)) + 128) >>> 8;
      ii  = (int'($signed(bi)) * int'(wis) + 128) >>> 8;
      ri  = (int'($signed(br)) * int'(wis) + 128) >>> 8;
      ir  = (int'($signed(bi)) * int'($signed(wr)) + 128) >>> 8;
      zr  = 16'(rr - ii);
      zi  = 16'(ri + ir);
      s[0] = int'($signed(ar)) + int'(zr);
      s[1] = int'($signed(ai)) + int'(zi);
      s[2] = int'($signed(ar)) - int'(zr);
      s[3] = int'($signed(ai)) - int'(zi);
      ov = 1'b0;
      for (int k = 0; k < 4; k++) begin
`ifdef BF_RADIX2_SAT_EN
         if (s[k] > 32767) begin
            y[k] = 16'h7FFF; ov = 1'b1;
         end else if (s[k] < -32768) begin
            y[k] = 16'h8000; ov = 1'b1;
         end else begin
            y[k] = 16'(s[k]);
         end
`else
         y[k] = 16'(s[k]);
`endif
      end
      return {ov, y[0], y[1], y[2], y[3]};
   endfunction

   task automatic apply_one(input logic [15:0] ar, ai, br, bi, wr, wi, input logic inv,
                            output logic [63:0] y, output logic ov, output int lat);
      @(negedge clk);
      bus.A_re = ar; bus.A_im = ai; bus.B_re = br; bus.B_im = bi;
      bus.W_re = wr; bus.W_im = wi; bus.inverse = inv;
      bus.in_valid = 1'b1; bus.out_ready = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      lat = 1;
      while (!bus.out_valid && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      y  = {bus.Y0_re, bus.Y0_im, bus.Y1_re, bus.Y1_im};
      ov = bus.ovf;
   endtask

   task automatic test_reset();
      int seen;
      rst = 1'b1;
      bus.in_valid = 1'b1; bus.out_ready = 1'b0; bus.inverse = 1'b0;
      bus.A_re = 16'h1234; bus.A_im = 16'h0; bus.B_re = 16'h0100; bus.B_im = 16'h0;
      bus.W_re = 16'h0100; bus.W_im = 16'h0;
      repeat (2) @(negedge clk);
      applied++;
      if (bus.out_valid !== 1'b0) begin
         miscompares++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
      end
      applied++;
      if (bus.ovf !== 1'b0) begin
         miscompares++; $display("FAIL reset_ovf: got %b expected 0", bus.ovf);
      end
      applied++;
      if (bus.in_ready !== 1'b1) begin
         miscompares++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
      end
      rst = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      seen = 0;
      repeat (5) begin
         @(negedge clk);
         if (bus.out_valid !== 1'b0) seen++;
      end
      applied++;
      if (seen != 0) begin
         miscompares++; $display("FAIL reset_accept: got %0d valid beats expected 0", seen);
      end
   endtask

   task automatic test_basic();
      logic [63:0] y; logic ov; int lat;
      apply_one(16'h0100, 16'h0, 16'h0100, 16'h0, 16'h0100, 16'h0, 1'b0, y, ov, lat);
      applied++;
      if (lat != 3) begin
         miscompares++; $display("FAIL basic_latency: got %0d expected 3", lat);
      end
      applied++;
      if (y !== 64'h0200_0000_0000_0000) begin
         miscompares++; $display("FAIL basic_value: got %h expected %h", y, 64'h0200_0000_0000_0000);
      end
   endtask

   task automatic test_inverse();
      logic [63:0] y; logic ov; int lat;
      apply_one(16'h0, 16'h0, 16'h0100, 16'h0, 16'h0, 16'h0100, 1'b0, y, ov, lat);
      applied++;
      if (y !== 64'h0000_0100_0000_FF00) begin
         miscompares++; $display("FAIL twiddle_fwd: got %h expected %h", y, 64'h0000_0100_0000_FF00);
      end
      apply_one(16'h0, 16'h0, 16'h0100, 16'h0, 16'h0, 16'h0100, 1'b1, y, ov, lat);
      applied++;
      if (y !== 64'h0000_FF00_0000_0100) begin
         miscompares++; $display("FAIL twiddle_inv: got %h expected %h", y, 64'h0000_FF00_0000_0100);
      end
   endtask

   task automatic test_rounding();
      logic [63:0] y; logic ov; int lat;
      apply_one(16'h0, 16'h0, 16'h0001, 16'h0, 16'h0080, 16'h0, 1'b0, y, ov, lat);
      applied++;
      if (y !== 64'h0001_0000_FFFF_0000) begin
         miscompares++; $display("FAIL round_half_pos: got %h expected %h", y, 64'h0001_0000_FFFF_0000);
      end
      apply_one(16'h0, 16'h0, 16'hFFFF, 16'h0, 16'h0080, 16'h0, 1'b0, y, ov, lat);
      applied++;
      if (y !== 64'h0) begin
         miscompares++; $display("FAIL round_half_neg: got %h expected %h", y, 64'h0);
      end
   endtask

   task automatic test_saturation();
      logic [63:0] y; logic ov; int lat;
      logic [63:0] exp_y;
      logic        exp_ov;
`ifdef BF_RADIX2_SAT_EN
      exp_y = 64'h7FFF_0000_7D00_0000; exp_ov = 1'b1;
`else
      exp_y = 64'h8100_0000_7D00_0000; exp_ov = 1'b0;
`endif
      apply_one(16'h7F00, 16'h0, 16'h0200, 16'h0, 16'h0100, 16'h0, 1'b0, y, ov, lat);
      applied++;
      if (y !== exp_y) begin
         miscompares++; $display("FAIL overflow_value: got %h expected %h", y, exp_y);
      end
      applied++;
      if (ov !== exp_ov) begin
         miscompares++; $display("FAIL overflow_flag: got %b expected %b", ov, exp_ov);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] v [8][6];
      logic        vi [8];
      logic [64:0] exp_q [8];
      int          sent, got, cyc;
      for (int i = 0; i < 8; i++) begin
         for (int j = 0; j < 6; j++) v[i][j] = 16'($urandom);
         vi[i]    = 1'($urandom);
         exp_q[i] = golden(v[i][0], v[i][1], v[i][2], v[i][3], v[i][4], v[i][5], vi[i]);
      end
      sent = 0; got = 0; cyc = 0;
      fork
         begin
            while (sent < 8 && cyc < 60) begin
               @(negedge clk);
               cyc++;
               bus.out_ready = !(cyc >= 4 && cyc <= 8);
               bus.A_re = v[sent][0]; bus.A_im = v[sent][1];
               bus.B_re = v[sent][2]; bus.B_im = v[sent][3];
               bus.W_re = v[sent][4]; bus.W_im = v[sent][5];
               bus.inverse = vi[sent]; bus.in_valid = 1'b1;
               #1;
               if (cyc >= 4 && cyc <= 8) begin
                  applied++;
                  if (bus.in_ready !== 1'b0) begin
                     miscompares++;
                     $display("FAIL stall_in_ready: cycle %0d got %b expected 0", cyc, bus.in_ready);
                  end
               end
               if (bus.in_ready === 1'b1) sent++;
            end
            @(negedge clk);
            bus.in_valid = 1'b0; bus.out_ready = 1'b1;
         end
         begin
            int guard;
            guard = 0;
            while (got < 8 && guard < 80) begin
               @(negedge clk);
               #2;
               guard++;
               if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                  applied++;
                  if ({bus.ovf, bus.Y0_re, bus.Y0_im, bus.Y1_re, bus.Y1_im} !== exp_q[got]) begin
                     miscompares++;
                     $display("FAIL stream_%0d: got %h expected %h", got,
                              {bus.ovf, bus.Y0_re, bus.Y0_im, bus.Y1_re, bus.Y1_im}, exp_q[got]);
                  end
                  got++;
               end
            end
         end
      join
      applied++;
      if (got != 8) begin
         miscompares++; $display("FAIL stream_count: got %0d results expected 8", got);
      end
   endtask

   task automatic test_reset_inflight();
      int stale;
      @(negedge clk);
      bus.out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         bus.A_re = 16'(16'h0100 * (k + 1)); bus.A_im = 16'h0;
         bus.B_re = 16'h0100; bus.B_im = 16'h0;
         bus.W_re = 16'h0100; bus.W_im = 16'h0;
         bus.inverse = 1'b0; bus.in_valid = 1'b1;
         @(negedge clk);
      end
      rst = 1'b1; bus.in_valid = 1'b0;
      #1;
      applied++;
      if (bus.in_ready !== 1'b1) begin
         miscompares++; $display("FAIL flush_in_ready: got %b expected 1", bus.in_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      applied++;
      if (bus.out_valid !== 1'b0) begin
         miscompares++; $display("FAIL flush_out_valid: got %b expected 0", bus.out_valid);
      end
      stale = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus.out_valid !== 1'b0) stale++;
      end
      applied++;
      if (stale != 0) begin
         miscompares++; $display("FAIL flush_stale: got %0d valid beats expected 0", stale);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_inverse();
      test_rounding();
      test_saturation();
      test_back_to_back();
      test_reset_inflight();
      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
